phoenix_switch_control: RTL

Per-router routing and arbitration unit. It consumes the routing requests (h) raised by the five phoenix input buffers and reads each requester's header flit. It computes an XY route, grants the request with ack_h when the target output is free, and drives the crossbar select tables. It frees an output port when the owning buffer drops sender at end of packet.

---
 rtl/phoenix_switch_control.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/phoenix_switch_control.sv
// Purpose : Phoenix router switch control: round-robin pick of a requesting input, XY route, crossbar allocation.
// Latency : h present after edge k -> ack_h pulse after edge k+3 (one cycle); grants at most one per 4 cycles.
// Backpr. : a request whose target output is busy is dropped for this round; the requester simply retries later.
// Ports   : clock/reset (sync, active-high); h, data_in, sender from the five input buffers;
//           ack_h grant pulse, free per-output availability, mux_in (per output: driving input),
//           mux_out (per input: allocated output), 3 bits per entry.
module phoenix_switch_control #(
    parameter logic [7:0] ADDRESS = 8'h00,
    parameter int         NPORT   = 5,
    parameter int         FLIT_W  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NPORT-1:0]      h,
    input  logic [NPORT*FLIT_W-1:0] data_in,
    input  logic [NPORT-1:0]      sender,
    output logic [NPORT-1:0]      ack_h,
    output logic [NPORT-1:0]      free,
    output logic [NPORT*3-1:0]    mux_in,
    output logic [NPORT*3-1:0]    mux_out
);

    localparam logic [2:0] EAST  = 3'd0;
    localparam logic [2:0] WEST  = 3'd1;
    localparam logic [2:0] NORTH = 3'd2;
    localparam logic [2:0] SOUTH = 3'd3;
    localparam logic [2:0] LOCAL = 3'd4;
    localparam logic [3:0] MY_X  = ADDRESS[7:4];
    localparam logic [3:0] MY_Y  = ADDRESS[3:0];

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_ROUTE, S_ACK} state_t;

    state_t             r_state;
    logic [2:0]         r_last;
    logic [2:0]         r_sel;
    logic [NPORT-1:0]   r_ack_h;
    logic [NPORT-1:0]   r_free;
    logic [NPORT-1:0]   r_sender_q;
    logic [NPORT*3-1:0] r_mux_in;
    logic [NPORT*3-1:0] r_mux_out;

    logic [2:0]         w_cand;
    logic [2:0]         w_next_sel;
    logic               w_found;
    logic [7:0]         w_hdr;
    logic [3:0]         w_tx;
    logic [3:0]         w_ty;
    logic [2:0]         w_out;
    logic [2:0]         w_src;
    logic [NPORT-1:0]   w_release;
    logic               w_unused_flit_bits;

    // Only the low byte of each header carries the destination address.
    assign w_unused_flit_bits = ^data_in;

    // Round-robin search starting just after the last winner, wrapping LOCAL -> EAST.
    always_comb begin
        w_cand     = r_last;
        w_next_sel = r_last;
        w_found    = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            w_cand = (w_cand == 3'(NPORT - 1)) ? 3'd0 : w_cand + 3'd1;
            if (!w_found && h[w_cand]) begin
                w_found    = 1'b1;
                w_next_sel = w_cand;
            end
        end
    end

    // XY routing on the selected input's header.
    always_comb begin
        w_hdr = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (r_sel == 3'(p)) begin
                w_hdr = data_in[p*FLIT_W +: 8];
            end
        end
        w_tx = w_hdr[7:4];
        w_ty = w_hdr[3:0];
        if (w_tx > MY_X) begin
            w_out = EAST;
        end else if (w_tx < MY_X) begin
            w_out = WEST;
        end else if (w_ty > MY_Y) begin
            w_out = NORTH;
        end else if (w_ty < MY_Y) begin
            w_out = SOUTH;
        end else begin
            w_out = LOCAL;
        end
    end

    // An allocated output frees up when its owning input's sender falls.
    // mux_in of a free output is stale, so the free bit gates it.
    always_comb begin
        w_release = '0;
        w_src     = '0;
        for (int o = 0; o < NPORT; o++) begin
            w_src        = r_mux_in[o*3 +: 3];
            w_release[o] = !r_free[o] && r_sender_q[w_src] && !sender[w_src];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ack_h    <= '0;
            r_free     <= '1;
            r_mux_in   <= '0;
            r_mux_out  <= '0;
            r_last     <= LOCAL;
            r_sel      <= '0;
            r_sender_q <= '0;
        end else begin
            r_sender_q <= sender;
            r_ack_h    <= '0;
            // Release and grant never hit the same output: a grant needs free=1, a release free=0.
            r_free     <= r_free | w_release;
            case (r_state)
                S_IDLE: begin
                    if (|h) begin
                        r_state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (w_found) begin
                        r_sel   <= w_next_sel;
                        r_last  <= w_next_sel;
                        r_state <= S_ROUTE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ROUTE: begin
                    if (r_free[w_out] && h[r_sel]) begin
                        r_ack_h[r_sel]             <= 1'b1;
                        r_free[w_out]              <= 1'b0;
                        r_mux_in[w_out*3 +: 3]     <= r_sel;
                        r_mux_out[r_sel*3 +: 3]    <= w_out;
                        r_state                    <= S_ACK;
                    end else begin
                        // Pointer already moved on, so a blocked requester cannot starve others.
                        r_state <= S_IDLE;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack_h   = r_ack_h;
    assign free    = r_free;
    assign mux_in  = r_mux_in;
    assign mux_out = r_mux_out;

endmodule
